up_down_modn_311: RTL and testbench

//  Parametrised modulo-N up/down counter. Successor to the fixed 4-bit up/down counter.

---
 rtl/counter_pkg_311.sv | 26 ++
 rtl/up_down_next_311.sv | 60 ++++++
 rtl/up_down_modn_311.sv | 63 ++++++
 tb/tb_up_down_modn_311.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg_311.sv
// Shared encodings and parameter checks for the counter library blocks.
// Direction and limit-mode values match the raw ud/sat port bits.
package counter_pkg_311;

  typedef enum logic {
    DirDown = 1'b0,
    DirUp   = 1'b1
  } dir_e;

  typedef enum logic {
    ModeWrap = 1'b0,
    ModeSat  = 1'b1
  } mode_e;

  // Legal modulus range is 2 .. 2**width; evaluated in 64 bits so width = 32 does not overflow.
  function automatic bit modulus_ok(input int unsigned width, input int unsigned modulus);
    longint unsigned span;
    span = longint'(1) << width;
    return (modulus >= 2) && (longint'(modulus) <= span);
  endfunction

  function automatic bit reset_val_ok(input int unsigned reset_val, input int unsigned modulus);
    return reset_val < modulus;
  endfunction

endpackage

// File: rtl/up_down_next_311.sv
// Combinational next-state logic for the modulo-N up/down counter: load clamp,
// step, wrap/saturate at the limits, and the terminal-count output for cascading.
module up_down_next_311
  import counter_pkg_311::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             ud,
  input  logic             sat,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_next,
  output logic             tc
);

  // Limits are compared against MODULUS-1, never the raw 2**WIDTH rollover.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  dir_e  dir;
  mode_e mode;
  logic  at_max;
  logic  at_min;

  assign dir    = dir_e'(ud);
  assign mode   = mode_e'(sat);
  assign at_max = (count == MaxVal);
  assign at_min = (count == '0);

  assign tc = en & (((dir == DirUp) & at_max) | ((dir == DirDown) & at_min));

  always_comb begin
    next_count = count;
    wrap_next  = 1'b0;
    if (load) begin
      next_count = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (dir == DirUp) begin
        if (!at_max) begin
          next_count = count + One;
        end else if (mode == ModeWrap) begin
          next_count = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          next_count = count - One;
        end else if (mode == ModeWrap) begin
          next_count = MaxVal;
          wrap_next  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/up_down_modn_311.sv
// Parametrised modulo-N up/down counter with load, enable, wrap/saturate mode,
// terminal count and a registered wrap pulse. Holds only the count and wrap registers.
module up_down_modn_311
  import counter_pkg_311::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_311,
  input  logic             reset_311,
  input  logic             en_311,
  input  logic             ud_311,
  input  logic             sat_311,
  input  logic             load_311,
  input  logic [WIDTH-1:0] load_val_311,
  output logic [WIDTH-1:0] count_311,
  output logic             tc_311,
  output logic             wrap_311
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("up_down_modn_311: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  if (!reset_val_ok(RESET_VAL, MODULUS)) begin : g_bad_reset_val
    $error("up_down_modn_311: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  up_down_next_311 #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count     (count_q),
    .ud        (ud_311),
    .sat       (sat_311),
    .en        (en_311),
    .load      (load_311),
    .load_val  (load_val_311),
    .next_count(count_d),
    .wrap_next (wrap_d),
    .tc        (tc_311)
  );

  always_ff @(posedge clk_311 or posedge reset_311) begin
    if (reset_311) begin
      count_q <= WIDTH'(RESET_VAL);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_311 = count_q;
  assign wrap_311  = wrap_q;

endmodule

// File: tb/tb_up_down_modn_311.sv
// Self-checking bench: vector table, hand-written corner sequences, a MODULUS=16 instance,
// a two-digit cascade and randomized traffic against an arithmetic reference model.
`timescale 1ns/10ps
module tb_up_down_modn_311;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, ud, sat, load;
  logic [3:0] lv;
  logic [3:0] cnt;
  logic       tc, wrap;

  logic       e16, u16, l16;
  logic [3:0] lv16, c16;
  logic       tc16, w16;

  logic       ce;
  logic [3:0] clo, chi;
  logic       tclo, tchi, wlo, whi;

  int n_tests = 0;
  int n_fail  = 0;

  always #0.5 clk = ~clk;

  up_down_modn_311 #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk_311(clk), .reset_311(rst), .en_311(en), .ud_311(ud), .sat_311(sat),
    .load_311(load), .load_val_311(lv), .count_311(cnt), .tc_311(tc), .wrap_311(wrap)
  );

  up_down_modn_311 #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk_311(clk), .reset_311(rst), .en_311(e16), .ud_311(u16), .sat_311(1'b0),
    .load_311(l16), .load_val_311(lv16), .count_311(c16), .tc_311(tc16), .wrap_311(w16)
  );

  up_down_modn_311 #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
    .clk_311(clk), .reset_311(rst), .en_311(ce), .ud_311(1'b1), .sat_311(1'b0),
    .load_311(1'b0), .load_val_311(4'd0), .count_311(clo), .tc_311(tclo), .wrap_311(wlo)
  );

  up_down_modn_311 #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
    .clk_311(clk), .reset_311(rst), .en_311(tclo), .ud_311(1'b1), .sat_311(1'b0),
    .load_311(1'b0), .load_val_311(4'd0), .count_311(chi), .tc_311(tchi), .wrap_311(whi)
  );

  typedef struct {
    logic       en, ud, sat, load;
    logic [3:0] lv;
    int         exp_tc, exp_cnt, exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic u, input logic s, input logic l,
                              input int v, input int t, input int c, input int w);
    vec_t r;
    r.en = e; r.ud = u; r.sat = s; r.load = l; r.lv = 4'(v);
    r.exp_tc = t; r.exp_cnt = c; r.exp_wrap = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #0.2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, nxt;
    bit mw, mtc;

    // Table, starting from reset value 0 with MODULUS 10.
    for (int i = 0; i < 9; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, i + 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1));   // 9 -> 0 wraps
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));   // wrap pulse lasts one cycle
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1));   // 0 -> 9 wraps downward
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 1, 0, 1, 9, 0, 9, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 1, 0, 0, 1, 9, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 1, 12, 0, 9, 0));  // clamped
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 0));
    vecs.push_back(mk(1, 1, 0, 1, 5, 0, 5, 0));   // load beats enable
    vecs.push_back(mk(0, 1, 0, 1, 9, 0, 9, 0));
    vecs.push_back(mk(1, 1, 0, 1, 2, 1, 2, 0));   // load beats a pending wrap
    vecs.push_back(mk(0, 0, 0, 1, 15, 0, 9, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 0));

    rst = 1'b1; en = 0; ud = 0; sat = 0; load = 0; lv = 0;
    e16 = 0; u16 = 0; l16 = 0; lv16 = 0; ce = 0;
    #4;
    check("reset_count", 32'(cnt), 0);
    check("reset_wrap", 32'(wrap), 0);
    #4;
    rst = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].en; ud = vecs[i].ud; sat = vecs[i].sat; load = vecs[i].load; lv = vecs[i].lv;
      #0.1;
      check($sformatf("vec%0d_tc", i), 32'(tc), vecs[i].exp_tc);
      tick();
      check($sformatf("vec%0d_count", i), 32'(cnt), vecs[i].exp_cnt);
      check($sformatf("vec%0d_wrap", i), 32'(wrap), vecs[i].exp_wrap);
    end

    // Async reset between edges clears count and a live wrap pulse.
    en = 0; ud = 0; sat = 0; load = 1; lv = 0;
    tick();
    en = 1; load = 0;
    tick();
    check("pre_async_count", 32'(cnt), 9);
    check("pre_async_wrap", 32'(wrap), 1);
    #0.2;
    rst = 1'b1;
    #0.1;
    check("async_count", 32'(cnt), 0);
    check("async_wrap", 32'(wrap), 0);
    tick();
    tick();
    check("reset_hold_count", 32'(cnt), 0);
    #0.1;
    rst = 1'b0; ud = 1;
    tick();
    check("post_reset_count", 32'(cnt), 1);
    check("post_reset_wrap", 32'(wrap), 0);
    en = 0;

    // MODULUS = 16 behaves as a plain binary counter.
    check("m16_reset", 32'(c16), 0);
    l16 = 1; lv16 = 4'd15;
    tick();
    check("m16_load15", 32'(c16), 15);
    l16 = 0; e16 = 1; u16 = 1;
    #0.1;
    check("m16_tc", 32'(tc16), 1);
    tick();
    check("m16_wrap_count", 32'(c16), 0);
    check("m16_wrap_pulse", 32'(w16), 1);
    e16 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("m16_hold%0d_count", i), 32'(c16), 0);
      check($sformatf("m16_hold%0d_wrap", i), 32'(w16), 0);
    end

    // Two-digit cascade 00..99 -> 00.
    rst = 1'b1;
    #0.2;
    rst = 1'b0;
    check("casc_start", 32'(chi) * 10 + 32'(clo), 0);
    ce = 1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      check($sformatf("casc_step%0d", i), 32'(chi) * 10 + 32'(clo), i % 100);
    end
    check("casc_hi_wrap", 32'(whi), 1);
    ce = 0;
    tick();
    check("casc_hi_wrap_end", 32'(whi), 0);

    // Randomized traffic against the arithmetic model.
    rst = 1'b1;
    #0.2;
    rst = 1'b0;
    m = 0;
    mw = 0;
    for (int k = 0; k < 400; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      ud   = 1'($urandom_range(0, 1));
      sat  = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 7) == 0);
      lv   = 4'($urandom_range(0, 15));
      #0.1;
      mtc = en && ((ud && m == M - 1) || (!ud && m == 0));
      check("rand_tc", 32'(tc), 32'(mtc));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #0.1;
        m = 0;
        mw = 0;
        check("rand_async_count", 32'(cnt), 0);
        check("rand_async_wrap", 32'(wrap), 0);
        #0.1;
        rst = 1'b0;
      end
      if (load) begin
        m  = (int'(lv) >= M) ? M - 1 : int'(lv);
        mw = 0;
      end else if (en) begin
        nxt = ud ? m + 1 : m - 1;
        mw  = 0;
        if (nxt < 0 || nxt >= M) begin
          if (!sat) begin
            m  = (nxt + M) % M;
            mw = 1;
          end
        end else begin
          m = nxt;
        end
      end else begin
        mw = 0;
      end
      tick();
      check("rand_count", 32'(cnt), m);
      check("rand_wrap", 32'(wrap), 32'(mw));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
